// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite agent definitions: access sizes, response codes and master FSM states.
package axi4lite_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd2;
  localparam logic [1:0] ERR_BUS   = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  // Size 3 is never legal; half/word must sit on their natural boundary.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (size_e'(size))
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/axi4lite_lane_align.sv
// Byte-lane steering for a 32-bit AXI4-Lite agent: write replication/strobes and
// read extraction, right-justified and zero-extended.
module axi4lite_lane_align
  import axi4lite_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata_in,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic [31:0] rdata_in,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_in >> {addr_lo, 3'b000};
    wdata   = wdata_in;
    wstrb   = 4'hF;
    rdata   = shifted;
    case (size_e'(size))
      SZ_BYTE: begin
        wdata = {4{wdata_in[7:0]}};
        wstrb = 4'b0001 << addr_lo;
        rdata = {24'd0, shifted[7:0]};
      end
      SZ_HALF: begin
        wdata = {2{wdata_in[15:0]}};
        wstrb = 4'b0011 << {addr_lo[1], 1'b0};
        rdata = {16'd0, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/axi4lite_sba_master.sv
// Single-outstanding AXI4-Lite initiator for system-bus access: one command in,
// one AXI4-Lite transaction out, one lane-aligned result back.
module axi4lite_sba_master
  import axi4lite_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter logic [2:0]  PROT   = 3'b000,
  parameter logic [3:0]  CACHE  = 4'b0000
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [1:0]        cmd_size,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awprot,
  output logic [3:0]        awcache,
  output logic              wvalid,
  input  logic              wready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arprot,
  output logic [3:0]        arcache,
  input  logic              rvalid,
  output logic              rready,
  input  logic [1:0]        rresp,
  input  logic [31:0]       rdata
);

  state_e            state;
  logic [1:0]        size_q;
  logic [1:0]        lo_q;
  logic              aw_done;
  logic              w_done;
  logic [1:0]        al_size;
  logic [1:0]        al_lo;
  logic [31:0]       al_wdata;
  logic [3:0]        al_wstrb;
  logic [31:0]       al_rdata;
  logic [ADDR_W-1:0] addr_aligned;

  assign addr_aligned = {cmd_addr[ADDR_W-1:2], 2'b00};

  // The aligner sees the live command while idle and the latched one afterwards.
  assign al_size = (state == ST_IDLE) ? cmd_size      : size_q;
  assign al_lo   = (state == ST_IDLE) ? cmd_addr[1:0] : lo_q;

  axi4lite_lane_align u_align (
    .size     (al_size),
    .addr_lo  (al_lo),
    .wdata_in (cmd_wdata),
    .wdata    (al_wdata),
    .wstrb    (al_wstrb),
    .rdata_in (rdata),
    .rdata    (al_rdata)
  );

  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign bready    = (state == ST_WRESP);
  assign arvalid   = (state == ST_RADDR);
  assign rready    = (state == ST_RDATA);
  assign awprot    = PROT;
  assign arprot    = PROT;
  assign awcache   = CACHE;
  assign arcache   = CACHE;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      size_q    <= 2'd0;
      lo_q      <= 2'd0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      awaddr    <= '0;
      araddr    <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= ERR_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            size_q    <= cmd_size;
            lo_q      <= cmd_addr[1:0];
            rsp_rdata <= '0;
            rsp_err   <= ERR_OK;
            if (misaligned(cmd_size, cmd_addr[1:0])) begin
              rsp_err <= ERR_ALIGN;
              state   <= ST_RESP;
            end else if (cmd_write) begin
              awaddr  <= addr_aligned;
              wdata   <= al_wdata;
              wstrb   <= al_wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
              state   <= ST_WADDR;
            end else begin
              araddr <= addr_aligned;
              state  <= ST_RADDR;
            end
          end
        end
        // AW and W complete independently; move on once both flags are set.
        ST_WADDR: begin
          if (awvalid && awready) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (wvalid && wready) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_done && w_done) state <= ST_WRESP;
        end
        ST_WRESP: begin
          if (bvalid) begin
            rsp_err <= (bresp != RESP_OKAY) ? ERR_BUS : ERR_OK;
            state   <= ST_RESP;
          end
        end
        ST_RADDR: begin
          if (arready) state <= ST_RDATA;
        end
        ST_RDATA: begin
          if (rvalid) begin
            rsp_rdata <= al_rdata;
            rsp_err   <= (rresp != RESP_OKAY) ? ERR_BUS : ERR_OK;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_sba_master.sv
// Directed bench for axi4lite_sba_master with a small stallable AXI4-Lite memory responder.
module tb_axi4lite_sba_master;

  logic        aclk;
  logic        aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic [3:0]  awcache;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic [3:0]  arcache;
  logic        rvalid, rready;
  logic [1:0]  rresp;
  logic [31:0] rdata;

  axi4lite_sba_master dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot), .awcache(awcache),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot), .arcache(arcache),
    .rvalid(rvalid), .rready(rready), .rresp(rresp), .rdata(rdata)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Responder knobs and observation counters
  int          cfg_aw_lat, cfg_w_lat, cfg_ar_lat;
  logic [1:0]  cfg_bresp, cfg_rresp;
  int          aw_cnt, w_cnt, ar_cnt;
  int          aw_hs, w_hs, b_hs, ar_hs, valid_cycles;
  logic        got_aw, got_w;
  logic [31:0] last_awaddr, last_wdata, last_araddr;
  logic [3:0]  last_wstrb;
  logic [31:0] mem [16] = '{default: 32'd0};

  assign awready = (aw_cnt >= cfg_aw_lat);
  assign wready  = (w_cnt >= cfg_w_lat);
  assign arready = (ar_cnt >= cfg_ar_lat);

  logic have_aw, have_w;
  assign have_aw = got_aw | (awvalid & awready);
  assign have_w  = got_w  | (wvalid & wready);

  always @(posedge aclk) begin
    if (awvalid || wvalid || arvalid) valid_cycles <= valid_cycles + 1;
    if (!aresetn) begin
      bvalid <= 1'b0; rvalid <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; bresp <= 2'b00; rresp <= 2'b00;
    end else begin
      if (awvalid && awready) begin
        aw_cnt <= 0; aw_hs <= aw_hs + 1; last_awaddr <= awaddr;
      end else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready) begin
        w_cnt <= 0; w_hs <= w_hs + 1; last_wdata <= wdata; last_wstrb <= wstrb;
      end else if (wvalid) w_cnt <= w_cnt + 1;
      if (bvalid && bready) begin
        bvalid <= 1'b0; b_hs <= b_hs + 1;
      end
      if (have_aw && have_w) begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) mem[awaddr[5:2]][b*8 +: 8] <= wdata[b*8 +: 8];
        bvalid <= 1'b1; bresp <= cfg_bresp; got_aw <= 1'b0; got_w <= 1'b0;
      end else begin
        got_aw <= have_aw; got_w <= have_w;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        ar_cnt <= 0; ar_hs <= ar_hs + 1; last_araddr <= araddr;
        rvalid <= 1'b1; rdata <= mem[araddr[5:2]]; rresp <= cfg_rresp;
      end else if (arvalid) ar_cnt <= ar_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    int          aw_lat;
    int          w_lat;
    logic [1:0]  br;
    logic [1:0]  rr;
    int          hold;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_err;
    int          exp_lat;
    logic        exp_bus;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_axaddr;
  } vec_t;

  // Drive one command, measure accept->rsp_valid latency, hold rsp_ready low if asked.
  task automatic run_cmd(input string tag, input vec_t v, output logic [31:0] rd,
                         output logic [1:0] er, output int lat);
    int guard;
    cfg_aw_lat = v.aw_lat; cfg_w_lat = v.w_lat; cfg_bresp = v.br; cfg_rresp = v.rr;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_size = v.sz; cmd_addr = v.addr;
    cmd_wdata = v.wd; rsp_ready = (v.hold == 0);
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge aclk); guard++; end
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(posedge aclk); #1; lat++; end
    rd = rsp_rdata; er = rsp_err;
    for (int h = 0; h < v.hold; h++) begin
      @(posedge aclk); #1;
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, rsp_rdata, v.exp_rdata);
      chk({tag, "_hold_err"}, 32'(rsp_err), 32'(v.exp_err));
    end
    if (v.hold != 0) begin @(negedge aclk); rsp_ready = 1'b1; end
    @(posedge aclk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_idle_after"}, {30'd0, cmd_ready, rsp_valid}, 32'd2);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    logic [31:0] rd;
    logic [1:0]  er;
    int lat, aw0, w0, b0, ar0, vc0;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; vc0 = valid_cycles;
    run_cmd(tag, v, rd, er, lat);
    chk({tag, "_err"}, 32'(er), 32'(v.exp_err));
    chk({tag, "_rdata"}, rd, v.exp_rdata);
    chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    if (!v.exp_bus) begin
      chk({tag, "_no_bus"}, 32'(valid_cycles - vc0), 32'd0);
    end else if (v.wr) begin
      chk({tag, "_aw_hs"}, 32'(aw_hs - aw0), 32'd1);
      chk({tag, "_w_hs"}, 32'(w_hs - w0), 32'd1);
      chk({tag, "_b_hs"}, 32'(b_hs - b0), 32'd1);
      chk({tag, "_awaddr"}, last_awaddr, v.exp_axaddr);
      chk({tag, "_wstrb"}, 32'(last_wstrb), 32'(v.exp_wstrb));
      chk({tag, "_wdata"}, last_wdata, v.exp_wdata);
    end else begin
      chk({tag, "_ar_hs"}, 32'(ar_hs - ar0), 32'd1);
      chk({tag, "_araddr"}, last_araddr, v.exp_axaddr);
    end
  endtask

  vec_t vecs [16];
  vec_t vr;

  initial begin
    //           wr    sz     addr          wdata        awl wl br     rr     hold rdata         err    lat bus   strb   wdata          axaddr
    vecs[0]  = '{1'b1, 2'd2, 32'h0000_7000, 32'hDEADBEEF, 0, 0, 2'b00, 2'b00, 0, 32'h0,        2'd0, 4, 1'b1, 4'hF, 32'hDEADBEEF, 32'h7000};
    vecs[1]  = '{1'b0, 2'd2, 32'h0000_7000, 32'h0,        0, 0, 2'b00, 2'b00, 0, 32'hDEADBEEF, 2'd0, 3, 1'b1, 4'h0, 32'h0,        32'h7000};
    vecs[2]  = '{1'b1, 2'd0, 32'h0000_7003, 32'h0000_00A5, 0, 0, 2'b00, 2'b00, 0, 32'h0,       2'd0, 4, 1'b1, 4'h8, 32'hA5A5A5A5, 32'h7000};
    vecs[3]  = '{1'b0, 2'd2, 32'h0000_7000, 32'h0,        0, 0, 2'b00, 2'b00, 0, 32'hA5ADBEEF, 2'd0, 3, 1'b1, 4'h0, 32'h0,        32'h7000};
    vecs[4]  = '{1'b0, 2'd0, 32'h0000_7003, 32'h0,        0, 0, 2'b00, 2'b00, 0, 32'h0000_00A5, 2'd0, 3, 1'b1, 4'h0, 32'h0,       32'h7000};
    vecs[5]  = '{1'b0, 2'd1, 32'h0000_7001, 32'h0,        0, 0, 2'b00, 2'b00, 0, 32'h0,        2'd2, 1, 1'b0, 4'h0, 32'h0,        32'h0};
    vecs[6]  = '{1'b0, 2'd2, 32'h0000_7002, 32'h0,        0, 0, 2'b00, 2'b00, 0, 32'h0,        2'd2, 1, 1'b0, 4'h0, 32'h0,        32'h0};
    vecs[7]  = '{1'b1, 2'd3, 32'h0000_7004, 32'hFFFFFFFF, 0, 0, 2'b00, 2'b00, 0, 32'h0,        2'd2, 1, 1'b0, 4'h0, 32'h0,        32'h0};
    vecs[8]  = '{1'b1, 2'd1, 32'h0000_7006, 32'h12345678, 0, 0, 2'b00, 2'b00, 0, 32'h0,        2'd0, 4, 1'b1, 4'hC, 32'h56785678, 32'h7004};
    vecs[9]  = '{1'b0, 2'd1, 32'h0000_7006, 32'h0,        0, 0, 2'b00, 2'b00, 0, 32'h0000_5678, 2'd0, 3, 1'b1, 4'h0, 32'h0,       32'h7004};
    vecs[10] = '{1'b1, 2'd2, 32'h0000_7008, 32'h11223344, 3, 0, 2'b00, 2'b00, 0, 32'h0,        2'd0, 7, 1'b1, 4'hF, 32'h11223344, 32'h7008};
    vecs[11] = '{1'b1, 2'd2, 32'h0000_700C, 32'h55667788, 0, 2, 2'b00, 2'b00, 0, 32'h0,        2'd0, 6, 1'b1, 4'hF, 32'h55667788, 32'h700C};
    vecs[12] = '{1'b0, 2'd2, 32'h0000_7008, 32'h0,        0, 0, 2'b00, 2'b00, 5, 32'h11223344, 2'd0, 3, 1'b1, 4'h0, 32'h0,        32'h7008};
    vecs[13] = '{1'b1, 2'd2, 32'h0000_7010, 32'hCAFEF00D, 0, 0, 2'b10, 2'b00, 0, 32'h0,        2'd3, 4, 1'b1, 4'hF, 32'hCAFEF00D, 32'h7010};
    vecs[14] = '{1'b0, 2'd2, 32'h0000_7010, 32'h0,        0, 0, 2'b00, 2'b11, 0, 32'hCAFEF00D, 2'd3, 3, 1'b1, 4'h0, 32'h0,        32'h7010};
    vecs[15] = '{1'b0, 2'd0, 32'h0000_700E, 32'h0,        0, 0, 2'b00, 2'b00, 0, 32'h0000_0066, 2'd0, 3, 1'b1, 4'h0, 32'h0,       32'h700C};

    aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'd0;
    cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    cfg_aw_lat = 0; cfg_w_lat = 0; cfg_ar_lat = 0; cfg_bresp = 2'b00; cfg_rresp = 2'b00;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; valid_cycles = 0;

    repeat (3) @(posedge aclk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_valids", {26'd0, rsp_valid, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_awaddr", awaddr, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_wstrb", 32'(wstrb), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    for (int i = 0; i < 16; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Reset while a read address is stalled by the responder
    cfg_ar_lat = 50;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 2'd2; cmd_addr = 32'h7000;
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    chk("rstmid_arvalid_pending", 32'(arvalid), 32'd1);
    @(negedge aclk);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    chk("rstmid_valids", {26'd0, rsp_valid, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    chk("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge aclk);
    aresetn = 1'b1;
    cfg_ar_lat = 0;
    vr = vecs[3];
    run_vec("after_rst", vr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi4lite_sba_master.md
# axi4lite_sba_master

Single-outstanding AXI4-Lite initiator that turns a simple valid/ready command (read or write, byte/half/word) into one AXI4-Lite transaction and returns a lane-aligned result with an error code. It is the initiator end of the 32-bit AXI4-Lite bus served by the mock SRAM responder. It sits behind the debug module's system-bus-access (SBA) path and drives the package's external memory port.

## Interface
Parameters:
- `ADDR_W`, 32: AXI address width.
- `PROT`, 3'b000: constant driven on `awprot`/`arprot`.
- `CACHE`, 4'b0000: constant driven on `awcache`/`arcache`.

Ports:
- `aclk`  in  1  clock; all logic on rising edge.
- `aresetn`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_size`  in  2  0 byte, 1 half, 2 word; 3 is illegal.
- `cmd_addr`  in  ADDR_W  byte address.
- `cmd_wdata`  in  32  write data, right-justified.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  result consumed.
- `rsp_rdata`  out  32  read data, right-justified, zero-extended; 0 for writes.
- `rsp_err`  out  2  0 ok, 2 misaligned/illegal size, 3 bus error.
- AXI4-Lite initiator: `awvalid` out 1, `awready` in 1, `awaddr` out ADDR_W, `awprot` out 3, `awcache` out 4, `wvalid` out 1, `wready` in 1, `wdata` out 32, `wstrb` out 4, `bvalid` in 1, `bready` out 1, `bresp` in 2, `arvalid` out 1, `arready` in 1, `araddr` out ADDR_W, `arprot` out 3, `arcache` out 4, `rvalid` in 1, `rready` out 1, `rresp` in 2, `rdata` in 32.

## Operation
- States: IDLE, WADDR (AW and/or W pending), WRESP, RADDR, RDATA, RESP.
- IDLE: `cmd_ready`=1. On accept, latch the command.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0) or size 3: go to RESP with err 2 and issue no bus activity.
  - Otherwise a write goes to WADDR and a read goes to RADDR.
- Address output: `awaddr`/`araddr` = addr with bits [1:0] cleared.
- Write lanes:
  - byte: wdata = {4{b}}, wstrb = 4'b0001<<addr[1:0].
  - half: wdata = {2{h}}, wstrb = 4'b0011<<{addr[1],1'b0}.
  - word: wdata as given, wstrb = 4'hF.
- WADDR: `awvalid` and `wvalid` rise together. Each drops independently the cycle after its own handshake. Go to WRESP once both have completed, in either order or simultaneously.
- WRESP: `bready`=1. On `bvalid`, go to RESP; err = 3 if `bresp`≠0, else 0.
- RADDR: `arvalid` held until `arready`, then RDATA.
- RDATA: `rready`=1. On `rvalid`, capture data as rdata >> (8·addr[1:0]) masked to the access size. Err = 3 if `rresp`≠0; rdata is still captured.
- RESP: `rsp_valid`=1 with data and err stable until `rsp_ready`, then IDLE.
- Valid signals never drop before their handshake, and address/data/strb stay stable while valid.

## Timing
- Reset values: `cmd_ready`=1 (IDLE); `rsp_valid`, `awvalid`, `wvalid`, `bready`, `arvalid`, `rready` = 0; `rsp_rdata`, `rsp_err`, `awaddr`, `araddr`, `wdata`, `wstrb` = 0.
- All outputs are registered or decoded from state only. There are no combinational paths from ready/valid inputs to outputs.
- Latencies:
  - Accept → `awvalid`/`wvalid`/`arvalid` high on the next cycle.
  - Misaligned accept → `rsp_valid` on the next cycle.
  - Zero-wait responder (ready already high, response one cycle after handshake): write accept→`rsp_valid` = 4 cycles; read = 3 cycles.
- `rsp_ready` may already be high when `rsp_valid` rises. The block then returns to IDLE the cycle after, and the next command is accepted no earlier than that.
- `aresetn` low mid-transaction: return to IDLE with all valids deasserted on the next edge. The block does not wait for bus completion; the responder shares the reset.

## Structure
- Shared package `axi4lite_pkg`: size enum (BYTE/HALF/WORD), rsp_err constants (OK=0, ALIGN=2, BUS=3), AXI resp constants, state enum.
- One sub-module, `axi4lite_lane_align`: combinational wstrb/wdata replication and rdata extraction, shared with other bus agents.

## Test plan
- Word write 0xDEADBEEF to 0x7000, then word read of 0x7000 → awaddr 0x7000, wstrb 0xF, rsp_rdata 0xDEADBEEF, err 0.
- Byte write 0xA5 to 0x7003 → wstrb 4'b1000, wdata 0xA5A5A5A5. A following word read returns 0xA5 in bits [31:24]. A byte read of 0x7003 → 0x000000A5.
- Half read of 0x7001 and word read of 0x7002 → each gives err 2 with no AW/AR activity, `rsp_valid` one cycle after accept.
- Responder stalls:
  - W accepted 3 cycles before AW → one B handshake, err 0.
  - awready and wready in the same cycle → one B handshake, err 0.
  - `rsp_ready` low for 5 cycles → response held stable.
- bresp 2'b10 on a write and rresp 2'b11 on a read → err 3; read data still captured.
- `aresetn` low while `arvalid` is pending → next cycle all valids are 0 and `cmd_ready`=1. The next command completes normally.
